// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared state encoding and width legality check for the vedic multipliers
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit-serial cores split operands into 2-bit digits, so widths must be even and at least two digits.
  function automatic bit width_ok(input int w);
    return ((w % 2) == 0) && (w >= 4);
  endfunction

endpackage

// File: rtl/vedic_two.sv
// rtl/vedic_two.sv - 2x2 unsigned vedic (urdhva-tiryagbhyam) multiplier core
module vedic_two (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  logic cross_hi;
  logic cross_lo;
  logic vert_hi;
  logic carry1;

  assign cross_hi = a_i[1] & b_i[0];
  assign cross_lo = a_i[0] & b_i[1];
  assign vert_hi  = a_i[1] & b_i[1];
  assign carry1   = cross_hi & cross_lo;

  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = cross_hi ^ cross_lo;
  assign p_o[2] = vert_hi ^ carry1;
  assign p_o[3] = vert_hi & carry1;

endmodule

// File: rtl/vedic_seq_ctrl.sv
// rtl/vedic_seq_ctrl.sv - sequential WIDTHxWIDTH multiplier sharing one 2x2 vedic core over all digit pairs
module vedic_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N = WIDTH / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("vedic_seq_ctrl: WIDTH must be even and >= 4");
  end

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   product_q;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [CNT_W-1:0]     i_q;
  logic [CNT_W-1:0]     j_q;
  logic [CNT_W+1:0]     shamt;
  logic [1:0]           a_dig;
  logic [1:0]           b_dig;
  logic [3:0]           pp;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  assign a_dig = a_q[{i_q, 1'b0} +: 2];
  assign b_dig = b_q[{j_q, 1'b0} +: 2];

  vedic_two u_core (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  // Digit pair (i,j) carries weight 4^(i+j).
  assign shamt  = ({2'b00, i_q} + {2'b00, j_q}) << 1;
  assign pp_ext = {{(2*WIDTH-4){1'b0}}, pp};
  assign acc_d  = acc_q + (pp_ext << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            // A zero operand makes the product zero; skip the digit sweep.
            if ((a == '0) || (b == '0)) begin
              state_q     <= DONE;
              product_q   <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              i_q         <= '0;
              state_q     <= DONE;
              product_q   <= acc_d;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_vedic_seq_ctrl.sv
// tb/tb_vedic_seq_ctrl.sv - self-checking bench for vedic_seq_ctrl at WIDTH=8 and WIDTH=4
module tb_vedic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vedic_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  vedic_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov4;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic [15:0] get_prod(input int w);
    return (w == 8) ? p8 : {8'h00, p4};
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [7:0] av, input logic [7:0] bv);
    if (w == 8) begin
      iv8 = v; a8 = av; b8 = bv;
    end else begin
      iv4 = v; a4 = av[3:0]; b4 = bv[3:0];
    end
  endtask

  task automatic set_ready(input int w, input logic v);
    if (w == 8) or8 = v;
    else or4 = v;
  endtask

  // Issues one operand pair into an idle DUT. lat counts clock edges after the
  // accept edge before out_valid is seen; it ends on the negedge where out_valid is high.
  task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv,
                    output int lat, output int bcnt);
    drive_in(w, 1'b1, av, bv);
    @(posedge clk); #1;
    drive_in(w, 1'b0, av, bv);
    lat = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (get_ov(w)) break;
      if (get_busy(w)) bcnt++;
      lat++;
      if (lat > 200) begin
        total++; bad++;
        $display("FAIL timeout_w%0d: out_valid still low after %0d cycles, want at most %0d", w, lat, (w/2)*(w/2));
        break;
      end
    end
  endtask

  task automatic finish_out(input int w);
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    set_ready(w, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({ir8, ov8, busy8} !== 3'b100) begin bad++; $display("FAIL reset_flags8: got %b want 100", {ir8, ov8, busy8}); end
    total++; if (p8 !== 16'h0000) begin bad++; $display("FAIL reset_prod8: got %h want 0000", p8); end
    total++; if ({ir4, ov4, busy4} !== 3'b100) begin bad++; $display("FAIL reset_flags4: got %b want 100", {ir4, ov4, busy4}); end
    total++; if (p4 !== 8'h00) begin bad++; $display("FAIL reset_prod4: got %h want 00", p4); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({ir8, ov8, busy8} !== 3'b100) begin bad++; $display("FAIL idle_after_reset8: got %b want 100", {ir8, ov8, busy8}); end
  endtask

  task automatic test_basic();
    int lat, bc;
    op(8, 8'hFF, 8'hFF, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency: got %0d want 16", lat); end
    total++; if (p8 !== 16'hFE01) begin bad++; $display("FAIL basic_product: got %h want fe01", p8); end
    total++; if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 16", bc); end
    total++; if (ir8 !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done: got %b want 0", ir8); end
    set_ready(8, 1'b1);
    @(posedge clk); #1;
    set_ready(8, 1'b0);
    @(negedge clk);
    total++; if ({ir8, ov8} !== 2'b10) begin bad++; $display("FAIL basic_return_idle: got %b want 10", {ir8, ov8}); end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [7:0] za [2];
    logic [7:0] zb [2];
    za[0] = 8'h00; zb[0] = 8'h5A;
    za[1] = 8'h5A; zb[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      op(8, za[k], zb[k], lat, bc);
      total++; if (lat !== 0) begin bad++; $display("FAIL zero%0d_latency: got %0d want 0 (valid in first cycle after accept)", k, lat); end
      total++; if (p8 !== 16'h0000) begin bad++; $display("FAIL zero%0d_product: got %h want 0000", k, p8); end
      total++; if (bc !== 0) begin bad++; $display("FAIL zero%0d_busy: got %0d busy cycles want 0", k, bc); end
      finish_out(8);
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [15:0] want;
    want = 16'(8'h12) * 16'(8'h34);
    op(8, 8'h12, 8'h34, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL bp_latency: got %0d want 16", lat); end
    for (int k = 0; k < 5; k++) begin
      total++; if (p8 !== want || ov8 !== 1'b1 || ir8 !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got p=%h ov=%b ir=%b want p=%h ov=1 ir=0", k, p8, ov8, ir8, want);
      end
      @(negedge clk);
    end
    set_ready(8, 1'b1);
    @(posedge clk); #1;
    set_ready(8, 1'b0);
    @(negedge clk);
    total++; if ({ir8, ov8} !== 2'b10) begin bad++; $display("FAIL bp_release: got %b want 10", {ir8, ov8}); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    drive_in(8, 1'b1, 8'hA5, 8'h3C);
    @(posedge clk); #1;
    drive_in(8, 1'b0, 8'hA5, 8'h3C);
    repeat (6) @(posedge clk);
    #2;
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL rst_mid_running: got busy=%b want 1", busy8); end
    rst_n = 1'b0;
    #1;
    total++; if ({ir8, ov8, busy8} !== 3'b100) begin bad++; $display("FAIL rst_mid_flags: got %b want 100", {ir8, ov8, busy8}); end
    total++; if (p8 !== 16'h0000) begin bad++; $display("FAIL rst_mid_product: got %h want 0000", p8); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(8, 8'h03, 8'h05, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL rst_after_latency: got %0d want 16", lat); end
    total++; if (p8 !== 16'h000F) begin bad++; $display("FAIL rst_after_product: got %h want 000f", p8); end
    finish_out(8);
  endtask

  task automatic test_back_to_back();
    int c1, c2, n;
    logic [15:0] pa, pb;
    c1 = 0; c2 = 0; pa = '0; pb = '0;
    set_ready(8, 1'b1);
    drive_in(8, 1'b1, 8'h01, 8'h01);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov8 && n < 100);
    c1 = cyc; pa = p8;
    drive_in(8, 1'b1, 8'h80, 8'h02);
    @(negedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov8 && n < 100);
    c2 = cyc; pb = p8;
    drive_in(8, 1'b0, 8'h80, 8'h02);
    @(posedge clk); #1;
    set_ready(8, 1'b0);
    total++; if (pa !== 16'h0001) begin bad++; $display("FAIL b2b_first: got %h want 0001", pa); end
    total++; if (pb !== 16'h0100) begin bad++; $display("FAIL b2b_second: got %h want 0100", pb); end
    total++; if (c2 - c1 !== 18) begin bad++; $display("FAIL b2b_interval: got %0d want 18", c2 - c1); end
  endtask

  task automatic test_random(input int w);
    int lat, bc, n, want_lat;
    logic [7:0]  av, bv;
    logic [15:0] want;
    n = w / 2;
    for (int k = 0; k < 1000; k++) begin
      av = 8'($urandom_range(0, (1 << w) - 1));
      bv = 8'($urandom_range(0, (1 << w) - 1));
      if ($urandom_range(0, 9) == 0) av = 8'h00;
      if ($urandom_range(0, 9) == 0) bv = 8'h00;
      want = 16'(av) * 16'(bv);
      want_lat = (av == 0 || bv == 0) ? 0 : n * n;
      op(w, av, bv, lat, bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      total++; if (get_prod(w) !== want) begin
        bad++; $display("FAIL rand%0d_product: a=%h b=%h got %h want %h", w, av, bv, get_prod(w), want);
      end
      total++; if (lat !== want_lat) begin
        bad++; $display("FAIL rand%0d_latency: a=%h b=%h got %0d want %0d", w, av, bv, lat, want_lat);
      end
      finish_out(w);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_in(8, 1'b0, 8'h00, 8'h00);
    drive_in(4, 1'b0, 8'h00, 8'h00);
    or8 = 1'b0;
    or4 = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random(8);
    test_random(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vedic_seq_ctrl.md
Name: vedic_seq_ctrl

Overview:
Sequential WIDTHxWIDTH unsigned multiplier controller that time-shares one 2x2 vedic multiplier core (vedic_two) across all 2-bit digit pairs of the operands. It accumulates shifted partial products over N*N cycles, where N=WIDTH/2. Valid/ready handshakes sit on both input and output. Intended as the area-minimal multiply unit beside the combinational vedic array multipliers.

Parameters:
WIDTH, 8, operand width in bits; must be even and >=4
N (localparam), WIDTH/2, number of 2-bit digits per operand
CNT_W (localparam), clog2(N) (min 1), width of each digit index counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a,b presented
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b, unsigned
busy  output  1  high in RUN state

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, acc=0, i=j=0, a_q=b_q=0. Reset takes effect immediately, including mid-RUN or in DONE. Any pending result is discarded.
- States: IDLE, RUN, DONE. in_ready=(state==IDLE), out_valid=(state==DONE), busy=(state==RUN).
- IDLE:
  - On in_valid&in_ready, capture a_q<=a, b_q<=b, acc<=0, i<=0, j<=0.
  - If a==0 or b==0, go directly to DONE with acc=0. Out_valid is then high 1 cycle after accept.
  - Otherwise go to RUN.
- RUN, one partial product per cycle:
  - pp = vedic_two(a_q[2i+1:2i], b_q[2j+1:2j]), 4 bits.
  - acc <= acc + (pp << 2*(i+j)); addition is 2*WIDTH wide and never overflows.
  - Index order: j increments each cycle. When j==N-1, j wraps to 0 and i increments.
  - On the cycle where i==N-1 and j==N-1, the final add occurs, i and j reset to 0, and the state goes to DONE.
- Latency: out_valid rises exactly N*N cycles after the accept edge (16 for WIDTH=8). Inputs are ignored while not in IDLE.
- DONE:
  - product = acc, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE. in_ready rises the next cycle, so there is no same-cycle output-to-input bypass.
  - Minimum issue interval is N*N+2 cycles for nonzero operands.
- product is registered and equals acc.
- In IDLE and RUN, product holds its last value, but is only meaningful when out_valid=1.
- out_ready asserted in a cycle without out_valid has no effect.
- in_valid held high across DONE->IDLE: the new operands are accepted on the first IDLE cycle.

Decomposition:
- Shared package vedic_pkg holds the state enum {IDLE, RUN, DONE} and a WIDTH legality check constant/function (even, >=4).
- Sub-module: exactly one existing vedic_two instance as the 2x2 core.
- Digit mux, shifter, accumulator and FSM stay inside vedic_seq_ctrl.

Test Plan:
- WIDTH=8: a=0xFF, b=0xFF, out_ready=1.
  - Required: out_valid rises exactly 16 cycles after the accept edge with product=0xFE01.
  - Required: busy is high for 16 cycles, and in_ready is high again 1 cycle after the out handshake.
- Zero shortcut: a=0x00, b=0x5A.
  - Required: DONE 1 cycle after accept, product=0x0000, busy never asserts.
  - Repeat with a=0x5A, b=0x00; same response required.
- Back-pressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid.
  - Required: product holds 0x03A8, in_ready stays 0.
  - Required: when out_ready=1, return to IDLE.
- Reset mid-operation: accept a=0xA5, b=0x3C, then drop rst_n at cycle 7 of RUN.
  - Required: all outputs return to reset values immediately.
  - Required: a new a=0x03, b=0x05 after reset yields product=0x000F at +16 cycles.
- Back-to-back with in_valid held high and out_ready=1.
  - Stimulus: a=0x01 b=0x01, then a=0x80 b=0x02.
  - Required: products 0x0001 then 0x0100, second out_valid 18 cycles after the first.
- Randomized: 1000 random pairs at WIDTH=8 and WIDTH=4.
  - Required: every product equals a*b, with latency N*N for nonzero operands and 1 for zero operands.
